// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and width helpers for alu_seq
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_PADD  = 4'd2,
    OP_AND   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_LUI   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_SLT   = 4'd10,
    OP_SRA   = 4'd11,
    OP_PADDS = 4'd12,
    OP_MUL   = 4'd13,
    OP_PSUB  = 4'd14,
    OP_RSVD  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_LANES     = 4;
  localparam int DEF_LUI_SHIFT = 12;

  function automatic int lane_width(input int width, input int lanes);
    return width / lanes;
  endfunction

  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// rtl/alu_iter_mul.sv - radix-2 shift-add multiplier, one multiplier bit per cycle
module alu_iter_mul import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      // done is held for one cycle after the last iteration so the owner can capture acc_q
      if (count_q == LAST) begin
        busy_q <= 1'b0;
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q + 1'b1;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (count_q == LAST);
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU: single-cycle datapath, packed lanes, iterative multiply
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int LUI_SHIFT = DEF_LUI_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sA,
  input  logic [WIDTH-1:0] sB,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int LW = lane_width(WIDTH, LANES);
  localparam int SW = shamt_width(WIDTH);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q, alu_d;
  logic             zero_q, out_valid_q;
  logic             accept, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] padd_w, psub_w, padds_w;
  logic [SW-1:0]    shamt;
  alu_op_e          op;

  assign op       = alu_op_e'(control);
  assign shamt    = sB[SW-1:0];
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Each lane carries its own carry bit so nothing propagates across lane boundaries
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LW:0]   sum;
    logic [LW-1:0] diff;
    assign sum  = {1'b0, sA[g*LW +: LW]} + {1'b0, sB[g*LW +: LW]};
    assign diff = sA[g*LW +: LW] - sB[g*LW +: LW];
    assign padd_w[g*LW +: LW]  = sum[LW-1:0];
    assign padds_w[g*LW +: LW] = sum[LW] ? {LW{1'b1}} : sum[LW-1:0];
    assign psub_w[g*LW +: LW]  = diff;
  end

  always_comb begin
    alu_d = '0;
    case (op)
      OP_ADD:   alu_d = sA + sB;
      OP_SUB:   alu_d = sA - sB;
      OP_PADD:  alu_d = padd_w;
      OP_AND:   alu_d = sA & sB;
      OP_SLTU:  alu_d = {{(WIDTH-1){1'b0}}, (sA < sB)};
      OP_LUI:   alu_d = {sB[WIDTH-1:LUI_SHIFT], {LUI_SHIFT{1'b0}}};
      OP_SLL:   alu_d = sA << shamt;
      OP_SRL:   alu_d = sA >> shamt;
      OP_OR:    alu_d = sA | sB;
      OP_XOR:   alu_d = sA ^ sB;
      OP_SLT:   alu_d = {{(WIDTH-1){1'b0}}, ($signed(sA) < $signed(sB))};
      OP_SRA:   alu_d = $signed(sA) >>> shamt;
      OP_PADDS: alu_d = padds_w;
      OP_PSUB:  alu_d = psub_w;
      default:  alu_d = '0;
    endcase
  end

  alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && (op == OP_MUL)),
    .a       (sA),
    .b       (sB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q     <= ST_MUL;
              out_valid_q <= 1'b0;
            end else begin
              result_q    <= alu_d;
              zero_q      <= (alu_d == '0);
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_q    <= mul_product;
            zero_q      <= (mul_product == '0);
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else if (!mul_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed bench for alu_seq at WIDTH=32/LANES=4 and WIDTH=64/LANES=8
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a_in, b_in;
  logic [3:0]  ctl;
  logic        iv, ordy, sel;

  logic        ir32, ov32, z32, ir64, ov64, z64;
  logic [31:0] r32;
  logic [63:0] r64;
  logic        cur_ir, cur_ov, cur_z;
  logic [63:0] cur_r;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_no = 0;

  typedef struct {
    logic [63:0] val;
    int          ready;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .LANES(4), .LUI_SHIFT(12)) dut32 (
    .clk(clk), .reset(rst), .in_valid(iv && !sel), .in_ready(ir32),
    .sA(a_in[31:0]), .sB(b_in[31:0]), .control(ctl),
    .out_valid(ov32), .out_ready(ordy), .result(r32), .zero(z32)
  );

  alu_seq #(.WIDTH(64), .LANES(8), .LUI_SHIFT(12)) dut64 (
    .clk(clk), .reset(rst), .in_valid(iv && sel), .in_ready(ir64),
    .sA(a_in), .sB(b_in), .control(ctl),
    .out_valid(ov64), .out_ready(ordy), .result(r64), .zero(z64)
  );

  assign cur_ir = sel ? ir64 : ir32;
  assign cur_ov = sel ? ov64 : ov32;
  assign cur_z  = sel ? z64 : z32;
  assign cur_r  = sel ? r64 : {32'b0, r32};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (W=%0d): got %0h expected %0h", nm, sel ? 64 : 32, act, exp);
    end
  endtask

  // Reference behaviour in plain 64-bit arithmetic, masked to the active width
  function automatic logic [63:0] model(input int op, input logic [63:0] a0, input logic [63:0] b0,
                                        input int w, input int lanes);
    logic [63:0] mask, a, b, msb, r, lmask, x, y, v;
    int sh, lw;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a     = a0 & mask;
    b     = b0 & mask;
    msb   = 64'd1 << (w - 1);
    sh    = int'(b % 64'(w));
    lw    = w / lanes;
    lmask = (64'd1 << lw) - 64'd1;
    r     = '0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      3:  r = a & b;
      4:  r = (a < b) ? 64'd1 : 64'd0;
      5:  r = b & ~64'hFFF;
      6:  r = a << sh;
      7:  r = a >> sh;
      8:  r = a | b;
      9:  r = a ^ b;
      10: r = ((a ^ msb) < (b ^ msb)) ? 64'd1 : 64'd0;
      11: r = (a & msb) != 0 ? ((a >> sh) | (mask & ~(mask >> sh))) : (a >> sh);
      13: r = a * b;
      2, 12, 14: begin
        for (int i = 0; i < lanes; i++) begin
          x = (a >> (i * lw)) & lmask;
          y = (b >> (i * lw)) & lmask;
          if (op == 2)       v = (x + y) & lmask;
          else if (op == 14) v = (x - y) & lmask;
          else               v = (x + y > lmask) ? lmask : x + y;
          r = r | (v << (i * lw));
        end
      end
      default: r = '0;
    endcase
    return r & mask;
  endfunction

  // Scoreboard: each accepted op becomes visible at a known edge and leaves when consumed
  always @(posedge clk) begin : model_p
    logic fr, irm;
    ent_t e;
    if (rst) begin
      q.delete();
      edge_no = edge_no + 1;
    end else begin
      fr  = (q.size() > 0) && (q[0].ready <= edge_no);
      irm = (q.size() == 0) || (fr && ordy);
      if (fr && ordy) void'(q.pop_front());
      edge_no = edge_no + 1;
      if (iv && irm) begin
        e.val   = model(int'(ctl), a_in, b_in, sel ? 64 : 32, sel ? 8 : 4);
        e.ready = edge_no + ((ctl == 4'd13) ? (sel ? 65 : 33) : 0);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : compare_p
    logic fr;
    if (!rst) begin
      fr = (q.size() > 0) && (q[0].ready <= edge_no);
      chk("cyc_out_valid", {63'b0, cur_ov}, {63'b0, fr});
      chk("cyc_in_ready", {63'b0, cur_ir}, {63'b0, (q.size() == 0) || (fr && ordy)});
      if (fr && cur_ov) begin
        chk("cyc_result", cur_r, q[0].val);
        chk("cyc_zero", {63'b0, cur_z}, {63'b0, q[0].val == 64'd0});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int n;
    iv = 1'b1; ctl = op; a_in = a; b_in = b;
    n = 0;
    while (!cur_ir && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("issue_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] e32, input logic [63:0] e64);
    logic [63:0] exp;
    int w, j, ir_hi;
    w   = sel ? 64 : 32;
    exp = sel ? e64 : e32;
    chk({nm, "_model"}, model(int'(op), a, b, w, sel ? 8 : 4), exp);
    issue(op, a, b);
    j = 0; ir_hi = 0;
    while (!cur_ov && j < 200) begin
      if (cur_ir) ir_hi++;
      @(posedge clk); #1; j++;
    end
    chk({nm, "_latency"}, 64'(j), (op == 4'd13) ? 64'(w + 1) : 64'd0);
    if (op == 4'd13) chk({nm, "_in_ready_busy"}, 64'(ir_hi), 64'd0);
    chk({nm, "_result"}, cur_r, exp);
    chk({nm, "_zero"}, {63'b0, cur_z}, {63'b0, exp == 64'd0});
    if (!ordy) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        chk({nm, "_hold_valid"}, {63'b0, cur_ov}, 64'd1);
        chk({nm, "_hold_result"}, cur_r, exp);
      end
      ordy = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, "_drained"}, {63'b0, cur_ov}, 64'd0);
  endtask

  task automatic suite();
    logic [3:0]  bop [4];
    logic [63:0] ba [4], bb [4], be [4];
    // Reset in the middle of a multiply
    ordy = 1'b1;
    issue(4'd13, 64'd7, 64'd9);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", {63'b0, cur_ov}, 64'd0);
    chk("rst_mid_result", cur_r, 64'd0);
    chk("rst_mid_zero", {63'b0, cur_z}, 64'd1);
    chk("rst_mid_in_ready", {63'b0, cur_ir}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("add", 4'd0, 64'd15, 64'd7, 64'd22, 64'd22);
    run_op("sub_zero", 4'd1, 64'd10, 64'd10, 64'd0, 64'd0);
    run_op("slt", 4'd10, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd1, 64'd1);
    run_op("sltu", 4'd4, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd0, 64'd0);
    run_op("padd", 4'd2, 64'hFF7F0102, 64'h01810304, 64'h00000406, 64'h00000406);
    run_op("padds", 4'd12, 64'hFF7F0102, 64'h01810304, 64'hFFFF0406, 64'hFFFF0406);
    run_op("psub", 4'd14, 64'd0, 64'h01010101_01010101, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
    run_op("mul", 4'd13, 64'h00010003, 64'd5, 64'h0005000F, 64'h0005000F);
    run_op("mul_neg", 4'd13, 64'hFFFFFFFF_FFFFFFFF, 64'd3, 64'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFFD);
    ordy = 1'b0;
    run_op("mul_hold", 4'd13, 64'h00010003, 64'd5, 64'h0005000F, 64'h0005000F);
    run_op("lui", 4'd5, 64'd0, 64'hFFC0003F, 64'hFFC00000, 64'hFFC00000);
    run_op("rsvd", 4'd15, 64'd5, 64'd6, 64'd0, 64'd0);
    run_op("and", 4'd3, 64'hF0F0, 64'hFF00, 64'hF000, 64'hF000);
    run_op("or", 4'd8, 64'hF0F0, 64'hFF00, 64'hFFF0, 64'hFFF0);
    run_op("srl", 4'd7, 64'h80000000, 64'd4, 64'h08000000, 64'h08000000);
    run_op("sll_wrap", 4'd6, 64'd1, 64'd64, 64'd1, 64'd1);

    // Back-to-back stream with in_valid and out_ready held high
    bop[0] = 4'd0;  ba[0] = 64'd1;                  bb[0] = 64'd1;
    bop[1] = 4'd9;  ba[1] = 64'hF0;                 bb[1] = 64'hFF;
    bop[2] = 4'd11; ba[2] = 64'hFFFFFFFF_80000000;  bb[2] = 64'd4;
    bop[3] = 4'd6;  ba[3] = 64'd1;                  bb[3] = 64'd33;
    be[0] = 64'd2;
    be[1] = 64'h0F;
    be[2] = sel ? 64'hFFFFFFFF_F8000000 : 64'hF8000000;
    be[3] = sel ? 64'h2_0000_0000 : 64'd2;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv = 1'b1; ctl = bop[i]; a_in = ba[i]; b_in = bb[i];
      @(posedge clk); #1;
      chk("b2b_valid", {63'b0, cur_ov}, 64'd1);
      chk("b2b_result", cur_r, be[i]);
    end
    iv = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drained", {63'b0, cur_ov}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; ordy = 1'b1; sel = 1'b0; ctl = 4'd0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'b0, cur_ov}, 64'd0);
    chk("reset_result", cur_r, 64'd0);
    chk("reset_zero", {63'b0, cur_z}, 64'd1);
    chk("reset_in_ready", {63'b0, cur_ir}, 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    suite();
    sel = 1'b1;
    @(posedge clk); #1;
    suite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation datapath ALU for the single-cycle CPU family. It extends the 8-op, 32-bit combinational ALU.
- Widths are parametrised. Packed-lane count is configurable, with wrapping and saturating lane modes, a signed compare and arithmetic shift.
- Multiply is iterative and takes multiple cycles. Operands and results move over a valid/ready handshake.
- Sits between the register-read stage and the writeback mux. The control unit stalls on in_ready and out_valid.

Parameters:
- WIDTH, 32: operand and result width. Must be at least 16 and a power of 2.
- LANES, 4: packed sub-words for PADD/PSUB/PADDS. WIDTH % LANES == 0; lane width LW = WIDTH/LANES.
- LUI_SHIFT, 12: number of low zero bits inserted by the LUI op.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  operands and op are presented
- in_ready  out  1  block can accept a new operation
- sA  in  WIDTH  operand A
- sB  in  WIDTH  operand B; shift amount = sB[$clog2(WIDTH)-1:0]
- control  in  4  opcode (see Behaviour)
- out_valid  out  1  result and zero are valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  registered result
- zero  out  1  registered, 1 when result == 0

Behaviour:
- Opcodes (values fixed):
  - 0 ADD; 1 SUB; 2 PADD (lanewise wrap); 3 AND; 4 SLTU (unsigned A<B -> 1, else 0); 5 LUI = {sB[WIDTH-1:LUI_SHIFT], LUI_SHIFT zeros}
  - 6 SLL; 7 SRL; 8 OR; 9 XOR; 10 SLT (signed); 11 SRA
  - 12 PADDS (lanewise unsigned saturating add, clamps to 2^LW-1); 13 MUL (low WIDTH bits of A*B); 14 PSUB (lanewise wrap); 15 reserved, result 0
- All arithmetic is modulo 2^WIDTH. Lane carries and borrows never cross lane boundaries.
- FSM states: IDLE, MUL, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). out_valid = (state==DONE).
- Accept occurs when in_valid & in_ready at a rising edge:
  - Any op other than MUL: result and zero are loaded at that edge; next state is DONE. Latency is 1 cycle.
  - MUL: operands are latched, count = 0, next state is MUL.
- MUL state: radix-2 shift-add, one multiplier bit per cycle, WIDTH iterations. On the final iteration, result and zero are loaded and next state is DONE. out_valid rises exactly WIDTH+1 edges after the accept edge.
- DONE with out_ready = 0: result and zero hold stable and out_valid stays 1, regardless of inputs.
- DONE with out_ready = 1 and in_valid = 0: next state is IDLE and out_valid drops.
- DONE with out_ready = 1 and in_valid = 1: the new op is accepted at the same edge (back-to-back). A single-cycle op loads the new result and stays in DONE; MUL goes to MUL. Sustained throughput is 1 op/cycle for non-MUL ops.
- In MUL state in_ready = 0, and in_valid is ignored. Inputs sA, sB and control are don't-care after the accept edge.
- Shifts use only the low $clog2(WIDTH) bits of sB: SLL by 32 on WIDTH=32 behaves as a shift by 0. SRA replicates sA[WIDTH-1].
- zero is the registered (result==0) of the loaded result, including for compare and LUI ops.
- Reset, asynchronous and valid at any time including mid-MUL: state=IDLE, result=0, zero=1, out_valid=0, in_ready=1, count=0, and the partial product is discarded.
- Out-of-range opcode 15 yields result=0, zero=1, with 1-cycle latency.

Decomposition:
- Shared package alu_pkg holds:
  - enum alu_op_e with the 16 opcode values above
  - FSM state enum {IDLE, MUL, DONE}
  - localparam helpers for LW and the shift-amount width
- Sub-module alu_iter_mul (parametrised WIDTH) wraps the shift-add multiplier and its counter. Ports: clk, reset, start, a, b, busy, done, product.
- alu_seq contains the handshake FSM, the combinational single-cycle datapath (a generate loop over LANES for the packed ops) and the output registers.

Test Plan:
- Reset asserted mid-MUL (A=7, B=9, assert at cycle 5) -> on reset, out_valid=0, result=0, zero=1, in_ready=1. A following ADD 15+7 -> result=22 one edge after accept.
- SUB 10-10 with out_ready=1 -> result=0, zero=1, latency 1. Then SLT A=0xFFFFFFFF, B=1 -> result=1. SLTU on the same operands -> result=0.
- PADD A=0xFF7F0102, B=0x01810304 (LANES=4) -> 0x00000406. PADDS on the same operands -> 0xFFFF0406. PSUB A=0x00000000, B=0x01010101 -> 0xFFFFFFFF.
- MUL A=0x0001_0003, B=0x0000_0005 -> out_valid exactly 33 edges after accept, result=0x0005_000F. in_ready=0 throughout. Hold out_ready=0 for 4 cycles -> result stable.
- Back-to-back: ADD 1+1, XOR 0xF0^0xFF, SRA 0x80000000>>>4, SLL 1<<33, with in_valid and out_ready held high -> results 2, 0x0F, 0xF8000000, 2 on consecutive cycles.
- LUI sB=0xFFC0003F -> 0xFFC00000. Opcode 15 -> 0 with zero=1. Rerun the suite with WIDTH=64, LANES=8 and check MUL latency is 65 edges.
